debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter NCH, default 8: number of independent input channels, 1..32.
REQ-002 SHALL have parameter NSYNC, default 3: synchroniser depth in flops, at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive disagreeing cycles required to change a clean output, at least 1.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50_000_000: cycles from rise to the first auto-repeat pulse, at least 1.
REQ-005 SHALL have parameter REPEAT_RATE, default 10_000_000: cycles between subsequent auto-repeat pulses, at least 1.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock for all logic.
REQ-007 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port noisy_in, input, NCH bits: raw asynchronous buttons/switches.
REQ-009 SHALL have port repeat_en, input, NCH bits: per-channel auto-repeat enable, sampled every cycle.
REQ-010 SHALL have port clean_out, output, NCH bits: debounced level.
REQ-011 SHALL have port rise_out, output, NCH bits: one-cycle pulse when clean_out goes 0->1.
REQ-012 SHALL have port fall_out, output, NCH bits: one-cycle pulse when clean_out goes 1->0.
REQ-013 SHALL have port press_out, output, NCH bits: one-cycle pulses at rise_out and at each auto-repeat, for menu up/down stepping.

Function
REQ-014 SHALL pass each noisy_in bit through NSYNC flops before any other use; no cross-channel logic.
REQ-015 SHALL increment a per-channel counter (width $clog2(DEBOUNCE_CYCLES+1)) on each cycle the synchronised bit differs from clean_out, and clear it on any cycle it agrees.
REQ-016 SHALL toggle clean_out at the edge where the counter would reach DEBOUNCE_CYCLES, clearing the counter at that same edge; total latency from an input step is NSYNC+DEBOUNCE_CYCLES edges.
REQ-017 SHALL register rise_out/fall_out so they are high exactly in the cycle clean_out first shows its new value; never both high together.
REQ-018 SHALL run a per-channel repeat FSM: IDLE -> WAIT on rise; WAIT -> REPEAT after REPEAT_DELAY cycles high; REPEAT emits a pulse every REPEAT_RATE cycles; any state -> IDLE on fall.
REQ-019 SHALL assert press_out with rise_out, and in WAIT->REPEAT and each REPEAT period only while repeat_en is 1; with repeat_en 0 the FSM runs but repeat pulses are suppressed.
REQ-020 SHALL give fall precedence: a repeat pulse due in the same cycle as fall_out is dropped.
REQ-021 SHALL saturate no counter; the repeat counter reloads on every pulse and on every rise.

Reset
REQ-022 SHALL, while rst_in is 0, force synchronisers, counters, clean_out, rise_out, fall_out and press_out to 0 and every FSM to IDLE, immediately and asynchronously.
REQ-023 SHALL, after reset deassertion with an input held high, debounce it as a fresh 0->1 step, producing rise_out and press_out.

Structure
REQ-024 SHALL place default cycle constants and the repeat-FSM state enum (IDLE, WAIT, REPEAT) in shared package input_pkg.
REQ-025 SHALL implement one channel in sub-module debounce_channel, instantiated NCH times via generate.

Verification (NCH=4, NSYNC=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-026 SHALL cover: step noisy_in[0] 0->1 at edge 0 -> clean_out[0], rise_out[0] and press_out[0] high at edge 10, with the pulses lasting one cycle.
REQ-027 SHALL cover: 7-cycle high glitch on noisy_in[1] -> no change on any output.
REQ-028 SHALL cover: noisy_in[2] toggled every 3 cycles for 30 cycles, then held high -> exactly one rise_out, 10 edges after the final toggle, with no fall_out.
REQ-029 SHALL cover: repeat_en[3]=1 and channel held for 50 cycles after rise -> press_out at offsets 0, 20, 25, 30, 35, 40, 45; release -> fall_out and no further press_out.
REQ-030 SHALL cover: rst_in pulled low mid-REPEAT with input still high -> all outputs 0 at once; after release, rise_out fires 10 edges later.
REQ-031 SHALL cover: channels 0 and 1 stepped in the same cycle -> identical, independent timing, with repeat_en[1]=0 giving no repeat pulses on channel 1.

Source files
------------

// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : input_pkg                                                 |
// | Description : Shared constants and repeat-FSM state encoding for the    |
// |               debounce bank.                                            |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package input_pkg;

  // Default timing, in clock cycles
  localparam int DEF_NCH             = 8;
  localparam int DEF_NSYNC           = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_RATE     = 10_000_000;

  // Auto-repeat state per channel
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Larger of two integers, used to size the shared repeat counter
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// | Module      : debounce_channel                                          |
// | Description : One button channel: synchroniser, debounce counter, edge  |
// |               pulses and auto-repeat state machine.                     |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_channel
  import input_pkg::*;
#(
  parameter int NSYNC           = DEF_NSYNC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic noisy_in,
  input  logic repeat_en,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic press_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

  // Counter value on the edge that completes each interval
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [NSYNC-1:0] sync;
  logic             synced;
  logic [CW-1:0]    db_cnt;
  logic             toggle;
  logic             went_high;
  logic             went_low;

  rpt_state_t       state;
  rpt_state_t       state_nxt;
  logic [RW-1:0]    rpt_cnt;
  logic [RW-1:0]    rpt_cnt_nxt;
  logic             press_nxt;

  assign synced    = sync[NSYNC-1];
  // The counter is one short of the threshold and the input still disagrees
  assign toggle    = (synced != clean_out) && (db_cnt == DB_LAST);
  assign went_high = toggle &  synced;
  assign went_low  = toggle & ~synced;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync <= '0;
    end else begin
      sync <= {sync[NSYNC-2:0], noisy_in};
    end
  end

  // Count disagreeing cycles; flip the clean level and flag the edge together
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      db_cnt    <= '0;
      clean_out <= 1'b0;
      rise_out  <= 1'b0;
      fall_out  <= 1'b0;
    end else begin
      rise_out <= went_high;
      fall_out <= went_low;
      if (toggle) begin
        clean_out <= synced;
        db_cnt    <= '0;
      end else if (synced != clean_out) begin
        db_cnt <= db_cnt + CW'(1);
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Repeat state, interval counter and press pulse register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      rpt_cnt   <= '0;
      press_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      press_out <= press_nxt;
    end
  end

  // Next repeat state; a falling edge overrides any pulse due in the same cycle
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    press_nxt   = 1'b0;
    if (went_low) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else if (went_high) begin
      state_nxt   = WAIT;
      rpt_cnt_nxt = '0;
      press_nxt   = 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (rpt_cnt == DELAY_LAST) begin
            state_nxt   = REPEAT;
            rpt_cnt_nxt = '0;
            press_nxt   = repeat_en;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == RATE_LAST) begin
            rpt_cnt_nxt = '0;
            press_nxt   = repeat_en;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// | Module      : debounce_bank                                             |
// | Description : Bank of NCH independent debounced button channels with    |
// |               rise/fall pulses and auto-repeat press pulses.            |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_bank
  import input_pkg::*;
#(
  parameter int NCH             = DEF_NCH,
  parameter int NSYNC           = DEF_NSYNC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [NCH-1:0] noisy_in,
  input  logic [NCH-1:0] repeat_en,
  output logic [NCH-1:0] clean_out,
  output logic [NCH-1:0] rise_out,
  output logic [NCH-1:0] fall_out,
  output logic [NCH-1:0] press_out
);

  // Channels share only clock and reset
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    debounce_channel #(
      .NSYNC          (NSYNC),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_channel (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .noisy_in (noisy_in[ch]),
      .repeat_en(repeat_en[ch]),
      .clean_out(clean_out[ch]),
      .rise_out (rise_out[ch]),
      .fall_out (fall_out[ch]),
      .press_out(press_out[ch])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// | Module      : tb_debounce_bank                                          |
// | Description : Directed self-checking bench for debounce_bank.           |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debounce_bank;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [3:0] noisy_in = 4'b0000;
  logic [3:0] repeat_en = 4'b0000;
  logic [3:0] clean_out;
  logic [3:0] rise_out;
  logic [3:0] fall_out;
  logic [3:0] press_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];

  debounce_bank #(
    .NCH            (4),
    .NSYNC          (2),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .noisy_in (noisy_in),
    .repeat_en(repeat_en),
    .clean_out(clean_out),
    .rise_out (rise_out),
    .fall_out (fall_out),
    .press_out(press_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected outputs for the next sample point
  task automatic push(input string tag, input logic [3:0] c, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] p);
    sb_t e;
    e.tag = tag;
    e.exp = {c, r, f, p};
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the outputs now
  task automatic check_now();
    sb_t         e;
    logic [15:0] obs;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e   = sb_q.pop_front();
    obs = {clean_out, rise_out, fall_out, press_out};
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: observed clean/rise/fall/press=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  // One clock: outputs after the next rising edge, sampled on the falling edge
  task automatic tick(input string tag, input logic [3:0] c, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] p);
    push(tag, c, r, f, p);
    @(negedge clk_in);
    check_now();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: everything quiet
    for (int k = 1; k <= 3; k++) tick("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_in = 1'b1;
    for (int k = 1; k <= 2; k++) tick("idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Channels 0 and 1 stepped together; only channel 0 repeats
    repeat_en = 4'b0001;
    noisy_in[1:0] = 2'b11;
    for (int k = 1; k <= 40; k++)
      tick("step01", {2'b00, k >= 10, k >= 10}, {2'b00, k == 10, k == 10}, 4'h0,
           {2'b00, k == 10, (k == 10 || k == 30 || k == 35 || k == 40)});
    // Release: the repeat pulse due with the fall is dropped
    noisy_in[1:0] = 2'b00;
    for (int k = 1; k <= 12; k++)
      tick("release01", {2'b00, k < 10, k < 10}, 4'h0, {2'b00, k == 10, k == 10},
           {3'b000, k == 5});

    // 7-cycle glitch on channel 1 never reaches the output
    repeat_en = 4'b0000;
    noisy_in[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick("glitch1", 4'h0, 4'h0, 4'h0, 4'h0);
      if (k == 7) noisy_in[1] = 1'b0;
    end

    // Channel 2 bounces every 3 cycles, settles high after the final toggle
    noisy_in[2] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick("bounce2", {1'b0, k >= 40, 2'b00}, {1'b0, k == 40, 2'b00}, 4'h0,
           {1'b0, k == 40, 2'b00});
      if (k % 3 == 0 && k <= 30) noisy_in[2] = ~noisy_in[2];
    end
    noisy_in[2] = 1'b0;
    for (int k = 1; k <= 12; k++)
      tick("release2", {1'b0, k < 10, 2'b00}, 4'h0, {1'b0, k == 10, 2'b00}, 4'h0);

    // Channel 3 auto-repeat, high for 50 cycles after the rise
    repeat_en = 4'b1000;
    noisy_in[3] = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      tick("repeat3", {(k >= 10 && k < 60), 3'b000}, {k == 10, 3'b000}, {k == 60, 3'b000},
           {(k == 10 || k == 30 || k == 35 || k == 40 || k == 45 || k == 50 || k == 55), 3'b000});
      if (k == 50) noisy_in[3] = 1'b0;
    end

    // Reset mid-REPEAT with the input still high
    noisy_in[3] = 1'b1;
    for (int k = 1; k <= 37; k++)
      tick("prerst3", {k >= 10, 3'b000}, {k == 10, 3'b000}, 4'h0,
           {(k == 10 || k == 30 || k == 35), 3'b000});
    #2;
    rst_in = 1'b0;
    push("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check_now();
    for (int k = 1; k <= 3; k++) tick("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_in = 1'b1;
    for (int k = 1; k <= 12; k++)
      tick("post_rst3", {k >= 10, 3'b000}, {k == 10, 3'b000}, 4'h0, {k == 10, 3'b000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
